// File: rtl/alu_seq.sv
// Sequential Hack-style ALU: single-cycle Hack functions plus an iterative
// shift-add multiply, with a valid/ready request side and a held result side.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             mul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshakes: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready.
    // Payloads are held stable while their valid is high and not yet taken.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] xl, yl;
    logic             zxl, nxl, zyl, nyl, nol;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] xp, yp, xi, yi;
    logic [WIDTH-1:0] step, acc_nxt, prod_out;
    logic [WIDTH-1:0] hack_r, hack_out;
    logic [WIDTH-1:0] res;
    logic             ld_out;

    function automatic logic [WIDTH-1:0] pre(input logic [WIDTH-1:0] v,
                                             input logic z, input logic n);
        logic [WIDTH-1:0] t;
        t = z ? '0 : v;
        return n ? ~t : t;
    endfunction

    // The multiplier works from the latched operands; one partial product per BUSY cycle.
    always_comb begin
        xp       = pre(xl, zxl, nxl);
        yp       = pre(yl, zyl, nyl);
        step     = yp[cnt] ? (xp << cnt) : '0;
        acc_nxt  = acc + step;
        prod_out = nol ? ~acc_nxt : acc_nxt;
    end

    // Single-cycle functions are evaluated on the accepting edge itself, where the
    // port values are exactly the ones being latched.
    always_comb begin
        xi       = pre(x, zx, nx);
        yi       = pre(y, zy, ny);
        hack_r   = f ? (xi + yi) : (xi & yi);
        hack_out = no ? ~hack_r : hack_r;
    end

    always_comb begin
        state_nxt = state;
        ld_out    = 1'b0;
        res       = '0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (mul) begin
                        state_nxt = BUSY;
                    end else begin
                        state_nxt = DONE;
                        ld_out    = 1'b1;
                        res       = hack_out;
                    end
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    ld_out    = 1'b1;
                    res       = prod_out;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xl  <= '0;
            yl  <= '0;
            zxl <= 1'b0;
            nxl <= 1'b0;
            zyl <= 1'b0;
            nyl <= 1'b0;
            nol <= 1'b0;
            acc <= '0;
            cnt <= '0;
        end else if (state == IDLE && in_valid) begin
            xl  <= x;
            yl  <= y;
            zxl <= zx;
            nxl <= nx;
            zyl <= zy;
            nyl <= ny;
            nol <= no;
            acc <= '0;
            cnt <= '0;
        end else if (state == BUSY) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
        end
    end

    // Result and flags change only when a result is produced; held through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
            zr  <= 1'b0;
            ng  <= 1'b0;
        end else if (ld_out) begin
            out <= res;
            zr  <= (res == '0);
            ng  <= res[WIDTH-1];
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against a plain-arithmetic model.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] x, y, out;
    logic         zx, nx, zy, ny, f, no, mul;
    logic         zr, ng, busy;
    logic [1:0]   dbg_state;

    logic         in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]   x8, y8, out8;
    logic         zr8, ng8, busy8;
    logic [1:0]   dbg_state8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .mul(mul), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .zr(zr), .ng(ng), .busy(busy), .dbg_state(dbg_state)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .x(x8), .y(y8), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .mul(mul), .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
        .zr(zr8), .ng(ng8), .busy(busy8), .dbg_state(dbg_state8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: operands preprocessed, then sum/and/product reduced mod 2^w.
    function automatic logic [31:0] model(input int w, input logic [31:0] xv, input logic [31:0] yv,
                                          input logic [5:0] c, input logic m);
        logic [63:0] mask, xp, yp, r;
        mask = (64'd1 << w) - 64'd1;
        xp = c[5] ? 64'd0 : (xv & mask);
        if (c[4]) xp = mask - xp;
        yp = c[3] ? 64'd0 : (yv & mask);
        if (c[2]) yp = mask - yp;
        if (m) r = (xp * yp) % (mask + 64'd1);
        else if (c[1]) r = (xp + yp) % (mask + 64'd1);
        else r = xp & yp;
        if (c[0]) r = mask - r;
        return r[31:0];
    endfunction

    // c = {zx, nx, zy, ny, f, no}
    task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [5:0] c,
                          input logic m, input logic [W-1:0] exp, input int hold);
        int lat, busy_n;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        x = xv; y = yv; {zx, nx, zy, ny, f, no} = c; mul = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = W'($urandom); y = W'($urandom); mul = 1'($urandom);
        lat = 0; busy_n = 0;
        while (!out_valid && lat < W + 5) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, m ? W : 0);
        if (m) check("busy_cycles", busy_n, W);
        check("out", out, exp);
        check("zr", zr, exp == '0);
        check("ng", ng, exp[W-1]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; x = W'($urandom); out_ready = 1'b0;
            @(posedge clk); #1;
            check("hold_out", out, exp);
            check("hold_flags", {zr, ng}, {exp == '0, exp[W-1]});
            check("hold_in_ready", in_ready, 0);
            check("hold_valid", out_valid, 1);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", in_ready, 1);
        check("release_valid", out_valid, 0);
        check("retain_out", out, exp);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rx, ry;
        logic [5:0]   rc;
        logic         rm;
        int           lat, seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        {zx, nx, zy, ny, f, no} = 6'b0; mul = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; x8 = '0; y8 = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", {out_valid, busy, zr, ng}, 4'b0);
        check("rst_out", out, 0);
        rst_n = 1'b1;

        // out_ready while idle must do nothing
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_out_ready", {in_ready, out_valid}, 2'b10);
        @(negedge clk); out_ready = 1'b0;

        run_op(16'd5, 16'd3, 6'b000010, 1'b0, 16'd8, 1);
        run_op(16'd3, 16'd5, 6'b010011, 1'b0, 16'hFFFE, 0);
        run_op(16'h00F0, 16'h0F00, 6'b000000, 1'b0, 16'h0000, 2);
        run_op(16'd300, 16'd300, 6'b000000, 1'b1, 16'h5F90, 0);
        run_op(16'hFFFF, 16'hFFFF, 6'b000000, 1'b1, 16'h0001, 0);
        run_op(16'h1234, 16'h00FF, 6'b000000, 1'b0, 16'h0034, 5);

        // WIDTH=8 multiply
        @(negedge clk);
        {zx, nx, zy, ny, f, no} = 6'b0; mul = 1'b1;
        x8 = 8'h0F; y8 = 8'h11; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8_latency", lat, 8);
        check("w8_out", out8, 8'hFF);
        check("w8_flags", {zr8, ng8}, 2'b01);
        @(negedge clk); out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("w8_release", in_ready8, 1);
        @(negedge clk); out_ready8 = 1'b0;

        for (int i = 0; i < 40; i++) begin
            rx = W'($urandom); ry = W'($urandom);
            rc = 6'($urandom);
            rm = ($urandom_range(0, 3) == 0);
            if (i % 8 == 0) rx = '0;
            if (i % 8 == 1) ry = {W{1'b1}};
            run_op(rx, ry, rc, rm, W'(model(W, 32'(rx), 32'(ry), rc, rm)), $urandom_range(0, 3));
        end

        // Reset in the 4th BUSY cycle abandons the multiply
        @(negedge clk);
        x = 16'd7; y = 16'd9; {zx, nx, zy, ny, f, no} = 6'b0; mul = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_state", {in_ready, out_valid, busy}, 3'b100);
        check("async_rst_out", {out, zr, ng}, '0);
        @(negedge clk);
        x = 16'd1; y = 16'd1; mul = 1'b0; f = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        check("no_accept_in_rst", {in_ready, out_valid, out}, {1'b1, 1'b0, 16'd0});
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("no_valid_after_rst", seen, 0);
        run_op(16'd5, 16'd3, 6'b000010, 1'b0, 16'd8, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Port clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 Port in_valid  input  1  operation request.
REQ-005 Port in_ready  output  1  block can accept an operation; SHALL be high exactly when state is IDLE.
REQ-006 Ports x, y  input  WIDTH  operands.
REQ-007 Ports zx, nx, zy, ny, f, no  input  1 each  Hack-style control bits.
REQ-008 Port mul  input  1  1 selects iterative multiply mode; 0 selects single-cycle Hack function.
REQ-009 Port out_valid  output  1  result available.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port out  output  WIDTH  registered result.
REQ-012 Ports zr, ng  output  1 each  registered flags: zr = (out == 0), ng = out[WIDTH-1].
REQ-013 Port busy  output  1  high while state is BUSY.

Function
REQ-014 States: IDLE, BUSY, DONE; the block SHALL have no other reachable states.
REQ-015 Accept: in IDLE, a rising edge with in_valid=1 SHALL latch x, y, all control bits and mul; in_valid is ignored in BUSY and DONE.
REQ-016 Preprocessing: x' = zx ? 0 : x, then x' = nx ? ~x' : x'; y' likewise with zy, ny; these SHALL be computed from the latched values.
REQ-017 mul=0: result r = f ? (x' + y') mod 2^WIDTH : (x' & y'); out = no ? ~r : r; carry discarded.
REQ-018 mul=0 latency: IDLE -> DONE on the edge after accept; out_valid SHALL be high 1 cycle after the accepting edge.
REQ-019 mul=1: IDLE -> BUSY on accept; a shift-add multiplier SHALL form the low WIDTH bits of x' * y' over exactly WIDTH BUSY cycles, with f ignored.
REQ-020 mul=1 output: out = no ? ~p : p, where p is the low product bits; BUSY -> DONE after the WIDTH-th BUSY cycle; out_valid SHALL be high WIDTH+1 cycles after the accepting edge.
REQ-021 The product SHALL equal the low WIDTH bits of both the signed and the unsigned product; no overflow flag is produced.
REQ-022 DONE: out_valid=1; out, zr and ng SHALL be held stable until a rising edge with out_ready=1, which returns the block to IDLE.
REQ-023 No same-cycle turnaround: in_ready SHALL be 0 in DONE, so a new accept can occur at the earliest the cycle after the output handshake.
REQ-024 out, zr and ng SHALL update only on the BUSY/IDLE -> DONE transition and SHALL retain their values in IDLE until the next result.
REQ-025 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, out=0, zr=0, ng=0, out_valid=0, busy=0 and the iteration counter to 0, regardless of clk.
REQ-027 in_ready SHALL read 1 during and after reset, but no accept SHALL occur while rst_n is low.
REQ-028 Reset asserted during BUSY or DONE SHALL abandon the operation; no out_valid SHALL be produced for it.

Verification
REQ-029 WIDTH=16, mul=0, zx/nx/zy/ny/no=0, f=1, x=5, y=3 -> out=8, zr=0, ng=0, out_valid 1 cycle after accept.
REQ-030 WIDTH=16, mul=0, controls 0,1,0,0,1,1 (x-y), x=3, y=5 -> out=0xFFFE, ng=1, zr=0.
REQ-031 WIDTH=16, mul=0, f=0, other controls 0, x=0x00F0, y=0x0F00 -> out=0x0000, zr=1, ng=0.
REQ-032 WIDTH=16, mul=1, other controls 0, x=300, y=300 -> out=0x5F90, busy high for 16 cycles, out_valid 17 cycles after accept; repeat with WIDTH=8, x=0x0F, y=0x11 -> out=0xFF, out_valid 9 cycles after accept.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing x -> out, zr, ng unchanged, in_ready=0, nothing accepted; then out_ready=1 -> IDLE on the next edge, in_ready=1.
REQ-034 Pulse rst_n low mid-multiply (cycle 4 of BUSY) -> all outputs reach reset values without a clock edge, no out_valid follows; a subsequent 5+3 operation returns 8.
